// File: rtl/mf_mac.sv
// rtl/mf_mac.sv - 20-term signed dot product with floor shift, 3-stage pipeline.
// Stages: products, four partial sums, full sum; res/pushout come straight from flops.
module mf_mac #(
    parameter int NTERMS = 20,
    parameter int SHIFT  = 35
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pushin,
    input  logic [31:0] d0,
    input  logic [31:0] d1,
    input  logic [31:0] d2,
    input  logic [31:0] d3,
    input  logic [31:0] d4,
    input  logic [31:0] d5,
    input  logic [31:0] d6,
    input  logic [31:0] d7,
    input  logic [31:0] d8,
    input  logic [31:0] d9,
    input  logic [31:0] d10,
    input  logic [31:0] d11,
    input  logic [31:0] d12,
    input  logic [31:0] d13,
    input  logic [31:0] d14,
    input  logic [31:0] d15,
    input  logic [31:0] d16,
    input  logic [31:0] d17,
    input  logic [31:0] d18,
    input  logic [31:0] d19,
    input  logic [31:0] w0,
    input  logic [31:0] w1,
    input  logic [31:0] w2,
    input  logic [31:0] w3,
    input  logic [31:0] w4,
    input  logic [31:0] w5,
    input  logic [31:0] w6,
    input  logic [31:0] w7,
    input  logic [31:0] w8,
    input  logic [31:0] w9,
    input  logic [31:0] w10,
    input  logic [31:0] w11,
    input  logic [31:0] w12,
    input  logic [31:0] w13,
    input  logic [31:0] w14,
    input  logic [31:0] w15,
    input  logic [31:0] w16,
    input  logic [31:0] w17,
    input  logic [31:0] w18,
    input  logic [31:0] w19,
    output logic        pushout,
    output logic [31:0] res
);
    localparam int NGRP = 4;

    logic signed [31:0] d_a [20];
    logic signed [31:0] w_a [20];

    assign d_a[0]  = d0;
    assign d_a[1]  = d1;
    assign d_a[2]  = d2;
    assign d_a[3]  = d3;
    assign d_a[4]  = d4;
    assign d_a[5]  = d5;
    assign d_a[6]  = d6;
    assign d_a[7]  = d7;
    assign d_a[8]  = d8;
    assign d_a[9]  = d9;
    assign d_a[10] = d10;
    assign d_a[11] = d11;
    assign d_a[12] = d12;
    assign d_a[13] = d13;
    assign d_a[14] = d14;
    assign d_a[15] = d15;
    assign d_a[16] = d16;
    assign d_a[17] = d17;
    assign d_a[18] = d18;
    assign d_a[19] = d19;
    assign w_a[0]  = w0;
    assign w_a[1]  = w1;
    assign w_a[2]  = w2;
    assign w_a[3]  = w3;
    assign w_a[4]  = w4;
    assign w_a[5]  = w5;
    assign w_a[6]  = w6;
    assign w_a[7]  = w7;
    assign w_a[8]  = w8;
    assign w_a[9]  = w9;
    assign w_a[10] = w10;
    assign w_a[11] = w11;
    assign w_a[12] = w12;
    assign w_a[13] = w13;
    assign w_a[14] = w14;
    assign w_a[15] = w15;
    assign w_a[16] = w16;
    assign w_a[17] = w17;
    assign w_a[18] = w18;
    assign w_a[19] = w19;

    logic signed [63:0] prod_d [20];
    logic signed [63:0] prod_q [20];
    logic signed [71:0] psum_d [NGRP];
    logic signed [71:0] psum_q [NGRP];
    logic signed [71:0] sum_d;
    logic signed [71:0] sum_q;
    logic        [31:0] res_d;
    logic        [31:0] res_q;
    logic               v1_q;
    logic               v2_q;
    logic               v3_q;
    logic               pushout_q;

    // Size casts keep signedness, so operands are sign-extended before the multiply.
    always_comb begin
        for (int i = 0; i < 20; i++) begin
            prod_d[i] = 64'(d_a[i]) * 64'(w_a[i]);
        end
    end

    always_comb begin
        for (int g = 0; g < NGRP; g++) begin
            psum_d[g] = '0;
        end
        for (int i = 0; i < NTERMS; i++) begin
            psum_d[i % NGRP] = psum_d[i % NGRP] + 72'(prod_q[i]);
        end
    end

    always_comb begin
        sum_d = '0;
        for (int g = 0; g < NGRP; g++) begin
            sum_d = sum_d + psum_q[g];
        end
    end

    // Arithmetic shift of a signed value floors toward minus infinity; upper bits drop.
    assign res_d = 32'(sum_q >>> SHIFT);

    always_ff @(posedge clk) begin
        if (reset) begin
            v1_q      <= 1'b0;
            v2_q      <= 1'b0;
            v3_q      <= 1'b0;
            pushout_q <= 1'b0;
            res_q     <= '0;
            sum_q     <= '0;
            for (int i = 0; i < 20; i++) begin
                prod_q[i] <= '0;
            end
            for (int g = 0; g < NGRP; g++) begin
                psum_q[g] <= '0;
            end
        end else begin
            v1_q      <= pushin;
            v2_q      <= v1_q;
            v3_q      <= v2_q;
            pushout_q <= v3_q;
            if (pushin) begin
                for (int i = 0; i < 20; i++) begin
                    prod_q[i] <= prod_d[i];
                end
            end
            if (v1_q) begin
                for (int g = 0; g < NGRP; g++) begin
                    psum_q[g] <= psum_d[g];
                end
            end
            if (v2_q) begin
                sum_q <= sum_d;
            end
            if (v3_q) begin
                res_q <= res_d;
            end
        end
    end

    assign pushout = pushout_q;
    assign res     = res_q;

endmodule

// File: tb/tb_mf_mac.sv
// tb/tb_mf_mac.sv - self-checking bench for mf_mac against a floor-division reference model.
module tb_mf_mac;
    logic        clk = 1'b0;
    logic        reset;
    logic        pushin;
    logic [31:0] d [20];
    logic [31:0] w [20];
    logic        pushout;
    logic [31:0] res;

    int          nchk  = 0;
    int          nfail = 0;
    int          cyc   = 0;
    int          due_q [$];
    logic [31:0] val_q [$];

    always #5 clk = ~clk;

    mf_mac dut (
        .clk(clk), .reset(reset), .pushin(pushin),
        .d0(d[0]), .d1(d[1]), .d2(d[2]), .d3(d[3]), .d4(d[4]),
        .d5(d[5]), .d6(d[6]), .d7(d[7]), .d8(d[8]), .d9(d[9]),
        .d10(d[10]), .d11(d[11]), .d12(d[12]), .d13(d[13]), .d14(d[14]),
        .d15(d[15]), .d16(d[16]), .d17(d[17]), .d18(d[18]), .d19(d[19]),
        .w0(w[0]), .w1(w[1]), .w2(w[2]), .w3(w[3]), .w4(w[4]),
        .w5(w[5]), .w6(w[6]), .w7(w[7]), .w8(w[8]), .w9(w[9]),
        .w10(w[10]), .w11(w[11]), .w12(w[12]), .w13(w[13]), .w14(w[14]),
        .w15(w[15]), .w16(w[16]), .w17(w[17]), .w18(w[18]), .w19(w[19]),
        .pushout(pushout), .res(res)
    );

    // Exact dot product, then floor(P / 2^35) by division with a negative-remainder fix-up.
    function automatic logic [31:0] ref_res();
        logic signed [127:0] p;
        logic signed [127:0] q;
        logic signed [127:0] dv;
        longint a;
        longint b;
        p  = '0;
        dv = 128'sd34359738368;
        for (int i = 0; i < 20; i++) begin
            a = longint'($signed(d[i]));
            b = longint'($signed(w[i]));
            p = p + a * b;
        end
        q = p / dv;
        if (p < 0 && q * dv != p) q = q - 1;
        return q[31:0];
    endfunction

    task automatic set_zero();
        for (int i = 0; i < 20; i++) begin
            d[i] = '0;
            w[i] = '0;
        end
    endtask

    task automatic set_garbage(input int k);
        for (int i = 0; i < 20; i++) begin
            case (k % 3)
                0:       begin d[i] = 32'hdeaddead; w[i] = 32'hdeaddead; end
                1:       begin d[i] = 32'hb0b11111; w[i] = 32'hb0b11111; end
                default: begin d[i] = $urandom;     w[i] = $urandom;     end
            endcase
        end
    endtask

    task automatic set_random();
        for (int i = 0; i < 20; i++) begin
            d[i] = ($urandom_range(0, 7) == 0) ? 32'h80000000 : $urandom;
            w[i] = ($urandom_range(0, 7) == 0) ? 32'h7fffffff : $urandom;
        end
    endtask

    task automatic step(input bit p, input bit r, input bit use_ref, input logic [31:0] expv);
        logic [31:0] e;
        e      = use_ref ? ref_res() : expv;
        reset  = r;
        pushin = p;
        @(posedge clk);
        cyc++;
        if (r) begin
            due_q.delete();
            val_q.delete();
        end else if (p) begin
            due_q.push_back(cyc + 3);
            val_q.push_back(e);
        end
        #1;
        if (r) begin
            nchk++;
            assert (res === 32'h0) else begin
                nfail++;
                $error("FAIL reset_res cyc=%0d observed=%h expected=00000000", cyc, res);
            end
        end
        if (due_q.size() > 0 && due_q[0] == cyc) begin
            nchk++;
            assert (pushout === 1'b1) else begin
                nfail++;
                $error("FAIL pushout_due cyc=%0d observed=%b expected=1", cyc, pushout);
            end
            nchk++;
            assert (res === val_q[0]) else begin
                nfail++;
                $error("FAIL res cyc=%0d observed=%h expected=%h", cyc, res, val_q[0]);
            end
            void'(due_q.pop_front());
            void'(val_q.pop_front());
        end else begin
            nchk++;
            assert (pushout === 1'b0) else begin
                nfail++;
                $error("FAIL pushout_idle cyc=%0d observed=%b expected=0", cyc, pushout);
            end
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            set_garbage(k);
            step(1'b0, 1'b0, 1'b0, 32'h0);
        end
    endtask

    initial begin
        reset  = 1'b1;
        pushin = 1'b0;
        set_zero();
        for (int k = 0; k < 3; k++) step(1'b0, 1'b1, 1'b0, 32'h0);

        // First edge out of reset carries the single-term push.
        set_zero();
        d[0] = 32'h40000000;
        w[0] = 32'h40000000;
        step(1'b1, 1'b0, 1'b0, 32'h02000000);
        idle(4);

        set_zero();
        d[5] = 32'hffffffff;
        w[5] = 32'h00000001;
        step(1'b1, 1'b0, 1'b0, 32'hffffffff);
        set_zero();
        d[5] = 32'h00000001;
        w[5] = 32'h00000001;
        step(1'b1, 1'b0, 1'b0, 32'h00000000);
        for (int i = 0; i < 20; i++) begin
            d[i] = 32'h80000000;
            w[i] = 32'h80000000;
        end
        step(1'b1, 1'b0, 1'b0, 32'ha0000000);
        idle(4);

        for (int n = 0; n < 200; n++) begin
            set_random();
            step(1'b1, 1'b0, 1'b1, 32'h0);
        end
        idle(4);

        for (int n = 0; n < 40; n++) begin
            set_random();
            step(1'b1, 1'b0, 1'b1, 32'h0);
            idle($urandom_range(0, 10));
        end
        idle(6);

        // Reset one edge after a push: that result must never appear.
        set_random();
        step(1'b1, 1'b0, 1'b1, 32'h0);
        set_garbage(0);
        step(1'b0, 1'b1, 1'b0, 32'h0);
        step(1'b0, 1'b1, 1'b0, 32'h0);
        for (int k = 0; k < 8; k++) begin
            set_garbage(k);
            step(1'b0, 1'b0, 1'b0, 32'h0);
            nchk++;
            assert (res === 32'h0) else begin
                nfail++;
                $error("FAIL post_reset_res cyc=%0d observed=%h expected=00000000", cyc, res);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
        $finish;
    end
endmodule
